pio_avalon_host: RTL and testbench

PIO_AVALON_HOST -- requirements
Module: pio_avalon_host

---
 rtl/pio_avalon_pkg.sv | 20 ++
 rtl/pio_poll_timer.sv | 31 +++
 rtl/pio_avalon_host.sv | 143 ++++++++++++++
 tb/tb_pio_avalon_host.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_avalon_pkg.sv
// Shared types and constants for the PIO Avalon-MM host.
package pio_avalon_pkg;

  // Host transaction sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // PIO slave register offsets.
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_IRQMASK = 2'd2;

  // Poll timer counter width; covers POLL_DIV up to 2^24-1.
  localparam int TIMER_W = 24;

endpackage

// File: rtl/pio_poll_timer.sv
// Free-running poll interval timer: counts 0..POLL_DIV-1 while enabled and
// pulses tick on the cycle it wraps back to 0. Disabling clears the count.
module pio_poll_timer
  import pio_avalon_pkg::*;
#(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(POLL_DIV - 1);

  logic [TIMER_W-1:0] count;

  // Interval counter with wrap and clear-on-disable.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + TIMER_W'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/pio_avalon_host.sv
// Avalon-MM host for a PIO slave. Serves single host commands (read/write)
// and, when enabled, periodic internal reads of the DATA register whose
// results land in poll_data.
//
// Command handshake: a command transfers on a rising edge where
// cmd_valid=1 and cmd_ready=1; cmd_ready is high only in IDLE, and the
// command fields need only be valid in that accepting cycle. Every accepted
// command ends with exactly one rsp_valid pulse; polls never pulse rsp_valid.
module pio_avalon_host
  import pio_avalon_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int POLL_DIV   = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  input  logic              poll_enable,
  output logic [DATA_W-1:0] poll_data,
  output logic              poll_changed,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [2:0]        dbg_state
);

  // Last RD_WAIT count; RD_WAIT spans RD_LATENCY cycles after RD_ADDR.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

  state_t     state, state_next;
  logic       accept_cmd;
  logic       take_poll;
  logic       sample;
  logic       is_poll;
  logic [1:0] wait_cnt;
  logic       poll_tick;
  logic       poll_pending;
  logic       poll_seen;

  pio_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (poll_enable),
    .tick   (poll_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; host commands take priority over a pending poll.
  always_comb begin
    state_next = state;
    accept_cmd = 1'b0;
    take_poll  = 1'b0;
    sample     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept_cmd = 1'b1;
          state_next = cmd_write ? ST_WR : ST_RD_ADDR;
        end else if (poll_pending) begin
          take_poll  = 1'b1;
          state_next = ST_RD_ADDR;
        end
      end
      ST_WR:      state_next = ST_DONE;
      ST_RD_ADDR: state_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          sample     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign cmd_ready      = (state == ST_IDLE);
  assign avm_chipselect = (state == ST_WR) || (state == ST_RD_ADDR);
  assign avm_write_n    = (state != ST_WR);
  assign dbg_state      = state;

  // Transaction datapath: latch command, count read latency, capture data.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_address   <= '0;
      avm_writedata <= '0;
      is_poll       <= 1'b0;
      wait_cnt      <= '0;
      rsp_valid     <= 1'b0;
      rsp_readdata  <= '0;
      poll_data     <= '0;
      poll_changed  <= 1'b0;
      poll_seen     <= 1'b0;
    end else begin
      rsp_valid    <= 1'b0;
      poll_changed <= 1'b0;
      if (accept_cmd) begin
        avm_address   <= cmd_address;
        avm_writedata <= cmd_writedata;
        is_poll       <= 1'b0;
      end else if (take_poll) begin
        avm_address <= REG_DATA;
        is_poll     <= 1'b1;
      end
      if (state == ST_RD_ADDR)      wait_cnt <= '0;
      else if (state == ST_RD_WAIT) wait_cnt <= wait_cnt + 2'd1;
      if (state == ST_WR) rsp_valid <= 1'b1;
      if (sample) begin
        if (is_poll) begin
          poll_data    <= avm_readdata;
          // The first poll after reset always reports a change.
          poll_changed <= !poll_seen || (avm_readdata != poll_data);
          poll_seen    <= 1'b1;
        end else begin
          rsp_readdata <= avm_readdata;
          rsp_valid    <= 1'b1;
        end
      end
    end
  end

  // Poll request flag; timer wraps while already pending merge into one poll.
  always_ff @(posedge clk) begin
    if (reset || !poll_enable) poll_pending <= 1'b0;
    else if (poll_tick)        poll_pending <= 1'b1;
    else if (take_poll)        poll_pending <= 1'b0;
  end

endmodule

// File: tb/tb_pio_avalon_host.sv
// Bench for pio_avalon_host: u1 (RD_LATENCY=1) and u2 (RD_LATENCY=3), both
// POLL_DIV=8, each attached to its own behavioural PIO slave.
module tb_pio_avalon_host;

  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic          cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic          cmd_write = 1'b0;
  logic [1:0]    cmd_address = '0;
  logic [DW-1:0] cmd_writedata = '0;
  logic          poll_enable = 1'b0, poll_enable2 = 1'b0;
  logic [DW-1:0] in_port = '0;

  // ---------------- DUT outputs ----------------
  logic cmd_ready1, rsp_valid1, poll_changed1, cs1, wn1;
  logic cmd_ready2, rsp_valid2, poll_changed2, cs2, wn2;
  logic [DW-1:0] rsp_rd1, poll_data1, wdata1, rdata1;
  logic [DW-1:0] rsp_rd2, poll_data2, wdata2, rdata2;
  logic [1:0] addr1, addr2;
  logic [2:0] dbg1, dbg2;

  pio_avalon_host #(.DATA_W(DW), .RD_LATENCY(1), .POLL_DIV(8)) u1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid1), .rsp_readdata(rsp_rd1), .poll_enable(poll_enable),
    .poll_data(poll_data1), .poll_changed(poll_changed1), .avm_address(addr1),
    .avm_chipselect(cs1), .avm_write_n(wn1), .avm_writedata(wdata1),
    .avm_readdata(rdata1), .dbg_state(dbg1));

  pio_avalon_host #(.DATA_W(DW), .RD_LATENCY(3), .POLL_DIV(8)) u2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid2), .rsp_readdata(rsp_rd2), .poll_enable(poll_enable2),
    .poll_data(poll_data2), .poll_changed(poll_changed2), .avm_address(addr2),
    .avm_chipselect(cs2), .avm_write_n(wn2), .avm_writedata(wdata2),
    .avm_readdata(rdata2), .dbg_state(dbg2));

  // ---------------- slave models ----------------
  // Registered read data delayed by the latency; non-read cycles carry a
  // filler pattern so a mistimed sample is visible.
  logic [DW-1:0] s1_regs[4] = '{default: '0};
  logic [DW-1:0] s2_regs[4] = '{default: '0};
  logic [DW-1:0] s1_pipe = 32'hDEAD_BEEF;
  logic [DW-1:0] s2_pipe[3] = '{default: 32'hDEAD_BEEF};

  always @(posedge clk) begin
    if (cs1 && !wn1) s1_regs[addr1] <= wdata1;
    s1_pipe <= (cs1 && wn1) ? ((addr1 == 2'd0) ? in_port : s1_regs[addr1]) : 32'hDEAD_BEEF;
    if (cs2 && !wn2) s2_regs[addr2] <= wdata2;
    s2_pipe[0] <= (cs2 && wn2) ? ((addr2 == 2'd0) ? in_port : s2_regs[addr2]) : 32'hDEAD_BEEF;
    s2_pipe[1] <= s2_pipe[0];
    s2_pipe[2] <= s2_pipe[1];
  end
  assign rdata1 = s1_pipe;
  assign rdata2 = s2_pipe[2];

  // ---------------- bus monitor ----------------
  int rsp1_cnt = 0, pc1_cnt = 0, rd1_cnt = 0, wr1_cnt = 0, rd2_cnt = 0, wr2_cnt = 0;
  logic [1:0]    wr1_addr = '0;
  logic [DW-1:0] wr1_data = '0;
  int rd1_cyc[$];
  logic [1:0] rd1_addr[$];

  always @(negedge clk) begin
    if (rsp_valid1) rsp1_cnt++;
    if (poll_changed1) pc1_cnt++;
    if (cs1 && wn1) begin rd1_cnt++; rd1_cyc.push_back(cyc); rd1_addr.push_back(addr1); end
    if (cs1 && !wn1) begin wr1_cnt++; wr1_addr = addr1; wr1_data = wdata1; end
    if (cs2 && wn2) rd2_cnt++;
    if (cs2 && !wn2) wr2_cnt++;
  end

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_regs[4] = '{default: '0};
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic host_cmd(input bit inst2, input logic w, input logic [1:0] a,
                          input logic [DW-1:0] d, output int lat,
                          output logic [DW-1:0] rdata, output bit addr_stable);
    int guard = 0;
    while (((inst2 ? cmd_ready2 : cmd_ready1) !== 1'b1) && guard < 50) begin
      step();
      guard++;
    end
    check("cmd_ready_wait", 32'(guard < 50), 32'd1);
    cmd_write = w; cmd_address = a; cmd_writedata = d;
    if (inst2) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    lat = 0;
    addr_stable = 1'b1;
    do begin
      step();
      lat++;
      if ((inst2 ? addr2 : addr1) !== a) addr_stable = 1'b0;
    end while (((inst2 ? rsp_valid2 : rsp_valid1) !== 1'b1) && lat < 20);
    rdata = inst2 ? rsp_rd2 : rsp_rd1;
  endtask

  // Reference: expected rsp_readdata and latency from the register rules.
  task automatic model_cmd(input logic w, input logic [1:0] a, input logic [DW-1:0] d,
                           input int rd_lat, output logic [DW-1:0] exp_rd, output int exp_lat);
    if (w) begin
      exp_rd = last_rd;
      exp_lat = 2;
      exp_regs[a] = d;
    end else begin
      exp_rd = (a == 2'd0) ? in_port : exp_regs[a];
      exp_lat = 2 + rd_lat;
      last_rd = exp_rd;
    end
  endtask

  typedef struct {
    logic [DW-1:0] in_port;
    logic          w;
    logic [1:0]    a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
    int            exp_lat;
  } vec_t;
  vec_t vecs[8];

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int lat, elat, wr0, rd0, rsp0, pc0, guard, p, win;
    logic [DW-1:0] rd, erd;
    bit stable;

    vecs[0] = '{32'h1,         1'b1, 2'd2, 32'h1,         32'h0,         2};
    vecs[1] = '{32'h1,         1'b0, 2'd0, 32'h0,         32'h1,         3};
    vecs[2] = '{32'hA5A5_0F0F, 1'b0, 2'd0, 32'h0,         32'hA5A5_0F0F, 3};
    vecs[3] = '{32'h0,         1'b0, 2'd2, 32'h0,         32'h1,         3};
    vecs[4] = '{32'h0,         1'b1, 2'd3, 32'hCAFE_F00D, 32'h1,         2};
    vecs[5] = '{32'h0,         1'b0, 2'd3, 32'h0,         32'hCAFE_F00D, 3};
    vecs[6] = '{32'h0,         1'b0, 2'd1, 32'h0,         32'h0,         3};
    vecs[7] = '{32'hFFFF_FFFF, 1'b0, 2'd0, 32'h0,         32'hFFFF_FFFF, 3};

    // Reset values.
    reset = 1'b1;
    repeat (3) step();
    check("rst_cmd_ready", 32'(cmd_ready1), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rst_poll_changed", 32'(poll_changed1), 32'd0);
    check("rst_chipselect", 32'(cs1), 32'd0);
    check("rst_write_n", 32'(wn1), 32'd1);
    check("rst_address", 32'(addr1), 32'd0);
    check("rst_rsp_readdata", rsp_rd1, 32'd0);
    check("rst_poll_data", poll_data1, 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_cmd_ready", 32'(cmd_ready1), 32'd1);

    // Table-driven host commands on u1.
    foreach (vecs[i]) begin
      in_port = vecs[i].in_port;
      wr0 = wr1_cnt; rd0 = rd1_cnt;
      model_cmd(vecs[i].w, vecs[i].a, vecs[i].d, 1, erd, elat);
      exp_q.push_back(vecs[i].exp_rd);
      host_cmd(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, lat, rd, stable);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_rdata", i), rd, exp_q.pop_front());
      check($sformatf("vec%0d_model", i), rd, erd);
      check($sformatf("vec%0d_wr_strobes", i), 32'(wr1_cnt - wr0), 32'(vecs[i].w));
      check($sformatf("vec%0d_rd_strobes", i), 32'(rd1_cnt - rd0), 32'(!vecs[i].w));
      if (vecs[i].w) begin
        check($sformatf("vec%0d_wr_addr", i), 32'(wr1_addr), 32'(vecs[i].a));
        check($sformatf("vec%0d_wr_data", i), wr1_data, vecs[i].d);
      end
    end

    // Randomized host commands on u1 against the register model.
    for (int i = 0; i < 30; i++) begin
      logic w;
      logic [1:0] a;
      logic [DW-1:0] d;
      w = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      in_port = $urandom;
      model_cmd(w, a, d, 1, erd, elat);
      host_cmd(1'b0, w, a, d, lat, rd, stable);
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(elat));
      check($sformatf("rand%0d_rdata", i), rd, erd);
      check($sformatf("rand%0d_addr_stable", i), 32'(stable), 32'd1);
    end

    // Polling: first poll always flags a change, unchanged values do not.
    in_port = 32'h0;
    pc0 = pc1_cnt; rsp0 = rsp1_cnt;
    poll_enable = 1'b1;
    guard = 0;
    while (pc1_cnt == pc0 && guard < 30) begin step(); guard++; end
    step();
    check("poll_first_changed", 32'(pc1_cnt - pc0), 32'd1);
    check("poll_first_data", poll_data1, 32'h0);
    pc0 = pc1_cnt; rd0 = rd1_cnt;
    repeat (40) step();
    check("poll_steady_no_pulse", 32'(pc1_cnt - pc0), 32'd0);
    check("poll_steady_reads", 32'((rd1_cnt - rd0) >= 4), 32'd1);
    in_port = 32'h1;
    pc0 = pc1_cnt;
    repeat (20) step();
    check("poll_toggle_pulse", 32'(pc1_cnt - pc0), 32'd1);
    check("poll_toggle_data", poll_data1, 32'h1);
    in_port = 32'h5A;
    pc0 = pc1_cnt;
    repeat (20) step();
    check("poll_change2_pulse", 32'(pc1_cnt - pc0), 32'd1);
    check("poll_change2_data", poll_data1, 32'h5A);
    check("poll_no_rsp", 32'(rsp1_cnt - rsp0), 32'd0);

    // Collision: host read issued in the same cycle the timer wraps.
    rd1_cyc.delete(); rd1_addr.delete();
    guard = 0;
    while (rd1_cyc.size() == 0 && guard < 20) begin step(); guard++; end
    check("coll_poll_seen", 32'(rd1_cyc.size() > 0), 32'd1);
    p = (rd1_cyc.size() > 0) ? rd1_cyc[0] : cyc;
    guard = 0;
    while (cyc < p + 6 && guard < 20) begin step(); guard++; end
    check("coll_align", 32'(cyc), 32'(p + 6));
    check("coll_ready", 32'(cmd_ready1), 32'd1);
    cmd_write = 1'b0; cmd_address = 2'd2; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (rsp_valid1 !== 1'b1 && lat < 20) begin step(); lat++; end
    check("coll_host_lat", 32'(lat), 32'd3);
    check("coll_host_rdata", rsp_rd1, exp_regs[2]);
    repeat (10) step();
    win = 0;
    foreach (rd1_cyc[i]) if (rd1_cyc[i] > p + 7 && rd1_cyc[i] < p + 16) win++;
    check("coll_read_count", 32'(rd1_cyc.size() >= 4), 32'd1);
    if (rd1_cyc.size() >= 4) begin
      check("coll_host_cycle", 32'(rd1_cyc[1]), 32'(p + 7));
      check("coll_host_addr", 32'(rd1_addr[1]), 32'd2);
      check("coll_poll_cycle", 32'(rd1_cyc[2]), 32'(p + 11));
      check("coll_poll_addr", 32'(rd1_addr[2]), 32'd0);
      check("coll_next_poll_cycle", 32'(rd1_cyc[3]), 32'(p + 16));
    end
    check("coll_single_poll", 32'(win), 32'd1);

    // Reset asserted while a read sits in RD_WAIT.
    poll_enable = 1'b0;
    repeat (6) step();
    in_port = 32'h1234_5678;
    cmd_write = 1'b0; cmd_address = 2'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp0 = rsp1_cnt;
    step();
    step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rw_chipselect", 32'(cs1), 32'd0);
    check("rw_write_n", 32'(wn1), 32'd1);
    check("rw_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rw_rsp_readdata", rsp_rd1, 32'd0);
    check("rw_poll_data", poll_data1, 32'd0);
    check("rw_address", 32'(addr1), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("rw_ready_after", 32'(cmd_ready1), 32'd1);
    repeat (4) step();
    check("rw_no_rsp", 32'(rsp1_cnt - rsp0), 32'd0);
    last_rd = '0;

    // Read latency 3 on u2.
    for (int i = 0; i < 3; i++) begin
      int r0;
      in_port = (i == 0) ? 32'h0BAD_F00D : $urandom;
      r0 = rd2_cnt;
      host_cmd(1'b1, 1'b0, 2'd0, 32'h0, lat, rd, stable);
      check($sformatf("lat3_%0d_lat", i), 32'(lat), 32'd5);
      check($sformatf("lat3_%0d_rdata", i), rd, in_port);
      check($sformatf("lat3_%0d_addr_stable", i), 32'(stable), 32'd1);
      check($sformatf("lat3_%0d_one_strobe", i), 32'(rd2_cnt - r0), 32'd1);
    end
    wr0 = wr2_cnt;
    host_cmd(1'b1, 1'b1, 2'd2, 32'h0000_0003, lat, rd, stable);
    check("lat3_wr_lat", 32'(lat), 32'd2);
    check("lat3_wr_strobe", 32'(wr2_cnt - wr0), 32'd1);
    host_cmd(1'b1, 1'b0, 2'd2, 32'h0, lat, rd, stable);
    check("lat3_irqmask_rdata", rd, 32'h0000_0003);
    check("lat3_irqmask_stable", 32'(stable), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
